// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with start/busy/done handshake and per-operation signed/unsigned mode.
// Radix-2 by default; define MULT_RADIX4_EN to build the radix-4 (modified Booth) datapath instead.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_total,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] operand_a_in,
  input  logic [WIDTH-1:0] operand_b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi_out,
  output logic [WIDTH-1:0] product_lo_out
);

`ifdef MULT_RADIX4_EN
  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = WIDTH + 4;  // headroom so A +/- 2M never overflows
  localparam int STEPS = (WIDTH + 2) / 2;
`else
  localparam int EXT_W = WIDTH + 1;
  localparam int ACC_W = WIDTH + 1;
  localparam int STEPS = WIDTH + 1;
`endif
  localparam int CNT_W  = $clog2(STEPS + 1);
  localparam int FULL_W = ACC_W + EXT_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ACC_W-1:0]  r_m;
  logic [ACC_W-1:0]  r_neg_m;
  logic [ACC_W-1:0]  r_a;
  logic [EXT_W-1:0]  r_q;
  logic              r_q_m1;
  logic [CNT_W-1:0]  r_count;
  logic              r_done;
  logic [WIDTH-1:0]  r_prod_hi;
  logic [WIDTH-1:0]  r_prod_lo;

  logic              w_sign_a;
  logic              w_sign_b;
  logic [ACC_W-1:0]  w_m_ext;
  logic [EXT_W-1:0]  w_q_ext;
  logic [ACC_W-1:0]  w_sum;
  logic [FULL_W-1:0] w_shifted;
  logic              w_q_m1_next;
  logic              w_last;

  // Operand extension: the extra MSBs let one datapath handle both signed and unsigned inputs.
  assign w_sign_a = signed_mode & operand_a_in[WIDTH-1];
  assign w_sign_b = signed_mode & operand_b_in[WIDTH-1];
  assign w_m_ext  = {{(ACC_W - WIDTH){w_sign_a}}, operand_a_in};
  assign w_q_ext  = {{(EXT_W - WIDTH){w_sign_b}}, operand_b_in};

  assign w_last = (r_state == ST_RUN) && (r_count == CNT_W'(1));

`ifdef MULT_RADIX4_EN
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_sum = r_a;
    case ({r_q[1:0], r_q_m1})
      3'b001, 3'b010: w_sum = r_a + r_m;
      3'b011:         w_sum = r_a + {r_m[ACC_W-2:0], 1'b0};
      3'b100:         w_sum = r_a + {r_neg_m[ACC_W-2:0], 1'b0};
      3'b101, 3'b110: w_sum = r_a + r_neg_m;
      default:        w_sum = r_a;
    endcase
  end

  assign w_shifted   = {{2{w_sum[ACC_W-1]}}, w_sum, r_q[EXT_W-1:2]};
  assign w_q_m1_next = r_q[1];
`else
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_sum = r_a;
    case ({r_q[0], r_q_m1})
      2'b10:   w_sum = r_a + r_neg_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
  end

  assign w_shifted   = {w_sum[ACC_W-1], w_sum, r_q[EXT_W-1:1]};
  assign w_q_m1_next = r_q[0];
`endif

  always_ff @(posedge clk) begin
    if (reset_total) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
    if (reset_total) begin
      r_m       <= '0;
      r_neg_m   <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q_m1    <= 1'b0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_m     <= w_m_ext;
          r_neg_m <= -w_m_ext;
          r_a     <= '0;
          r_q     <= w_q_ext;
          r_q_m1  <= 1'b0;
          r_count <= CNT_W'(STEPS);
        end
      end else begin
        r_a     <= w_shifted[FULL_W-1:EXT_W];
        r_q     <= w_shifted[EXT_W-1:0];
        r_q_m1  <= w_q_m1_next;
        r_count <= r_count - CNT_W'(1);
        // Final step: the shifted {A,Q} already holds the complete product.
        if (w_last) begin
          r_prod_hi <= w_shifted[2*WIDTH-1:WIDTH];
          r_prod_lo <= w_shifted[WIDTH-1:0];
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign busy           = (r_state == ST_RUN);
  assign done           = r_done;
  assign product_hi_out = r_prod_hi;
  assign product_lo_out = r_prod_lo;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=32): cycle-level reference model plus directed vectors.
// Honours MULT_RADIX4_EN for the expected latency.
`timescale 1ns/1ps
module tb_booth_mult_seq;
  localparam int W = 32;
`ifdef MULT_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         reset_total;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi_out;
  logic [W-1:0] product_lo_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_total   (reset_total),
    .start         (start),
    .signed_mode   (signed_mode),
    .operand_a_in  (a),
    .operand_b_in  (b),
    .busy          (busy),
    .done          (done),
    .product_hi_out(product_hi_out),
    .product_lo_out(product_lo_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    logic [2*W-1:0] xe;
    logic [2*W-1:0] ye;
    xe = {{W{s & x[W-1]}}, x};
    ye = {{W{s & y[W-1]}}, y};
    return xe * ye;
  endfunction

  // Reference model: fixed latency, exact product, busy-ignores-start.
  logic           m_busy;
  logic           m_done;
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  int             m_cnt;
  logic [2*W-1:0] m_pending;

  always @(posedge clk) begin
    if (reset_total) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_hi, m_lo} = m_pending;
        end
      end else if (start) begin
        m_busy    = 1'b1;
        m_cnt     = LAT;
        m_pending = ref_prod(signed_mode, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model busy", busy, m_busy);
      check("model done", done, m_done);
      check("model hi", product_hi_out, m_hi);
      check("model lo", product_lo_out, m_lo);
    end
  end

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following the done cycle.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    int cyc;
    signed_mode = s;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_mode = ~s;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, LAT);
    check({name, " hi"}, product_hi_out, eh);
    check({name, " lo"}, product_lo_out, el);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int dones;
    reset_total = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_total = 1'b0;
    cmp_en      = 1'b1;

    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset hi", product_hi_out, 32'h0);
    check("reset lo", product_lo_out, 32'h0);

    run_op("s -3x7", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("u ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("s ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("s minneg", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("u zero", 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
    run_op("s max x min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("u msb x2", 1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000);

    // Second start mid-operation must be ignored.
    signed_mode = 1'b1;
    a = 32'd5;
    b = 32'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    repeat (9) begin
      @(posedge clk); #1;
      cyc++;
    end
    a = 32'd100;
    b = 32'd200;
    start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ignore latency", cyc, LAT);
    check("ignore hi", product_hi_out, 32'h0);
    check("ignore lo", product_lo_out, 32'd30);
    dones = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("ignore single done", dones, 0);

    // Start held through the done cycle: back-to-back operations.
    signed_mode = 1'b0;
    a = 32'd1000;
    b = 32'd3000;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b first latency", cyc, LAT);
    check("b2b first lo", product_lo_out, 32'd3000000);
    a = 32'h0000_FFFF;
    b = 32'h0001_0001;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b second spacing", cyc, 2 * LAT + 1);
    check("b2b second hi", product_hi_out, 32'h0);
    check("b2b second lo", product_lo_out, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Reset in the middle of an operation aborts it.
    signed_mode = 1'b1;
    a = 32'h0001_2345;
    b = 32'h0000_0777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset_total = 1'b1;
    @(posedge clk); #1;
    reset_total = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort hi", product_hi_out, 32'h0);
    check("abort lo", product_lo_out, 32'h0);
    dones = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("abort no done", dones, 0);
    run_op("post-reset 2x3", 1'b0, 32'd2, 32'd3, 32'h0, 32'd6);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
